// File: rtl/pipe_spawner_multi_if.sv
// Pipe engine bundle: spawn controls from the game logic, per-slot geometry to the renderer.
// Spawn and movement requests cannot be refused; a spawn with no free slot shows up as spawnDrop.
interface pipe_spawner_multi_if #(parameter int N_PIPES = 3);
    logic                    tick;
    logic                    spawnReq;
    logic [9:0]              gapY;
    logic [9:0]              score;
    logic [N_PIPES*10-1:0]   pipeX;
    logic [N_PIPES*10-1:0]   gapTop;
    logic [N_PIPES*10-1:0]   gapBottom;
    logic [N_PIPES-1:0]      upVisible;
    logic [N_PIPES-1:0]      downVisible;
    logic [N_PIPES-1:0]      passed;
    logic                    spawnDrop;
    logic                    allBusy;

    modport master (
        output tick, spawnReq, gapY, score,
        input  pipeX, gapTop, gapBottom, upVisible, downVisible, passed, spawnDrop, allBusy
    );

    modport slave (
        input  tick, spawnReq, gapY, score,
        output pipeX, gapTop, gapBottom, upVisible, downVisible, passed, spawnDrop, allBusy
    );
endinterface

// File: rtl/pipe_spawner_multi.sv
// N-slot pipe obstacle engine: spawn on request edge, scroll left per tick, retire at screen edge.
// Spawn edge -> slot visible next edge; no backpressure, an edge with no free slot pulses spawnDrop.
module pipe_spawner_multi #(
    parameter int N_PIPES          = 3,
    parameter int FRAC_BITS        = 7,
    parameter int SPAWN_X          = 650,
    parameter int SCREEN_H         = 480,
    parameter int MIN_SPEED        = 192,
    parameter int SPEED_PER_SCORE  = 64,
    parameter int MAX_SPEED        = 1024,
    parameter int DOUBLE_MIN_SCORE = 10,
    parameter int BASE_GAP         = 200,
    parameter int GAP_STEP         = 30,
    parameter int MIN_GAP          = 100
) (
    input logic                 animationCLOCK,
    input logic                 resetN,
    pipe_spawner_multi_if.slave bus
);
    localparam int             XW        = 10 + FRAC_BITS;
    localparam logic [XW-1:0]  SPAWN_POS = XW'(SPAWN_X << FRAC_BITS);
    localparam int             MID       = SCREEN_H / 2;

    typedef enum logic {IDLE, ACTIVE} slot_state_t;

    slot_state_t        state_q [N_PIPES];
    slot_state_t        state_d [N_PIPES];
    logic [XW-1:0]      pos_q   [N_PIPES];
    logic [XW-1:0]      pos_d   [N_PIPES];
    logic [9:0]         y_q     [N_PIPES];
    logic [9:0]         y_d     [N_PIPES];
    logic [9:0]         score_q [N_PIPES];
    logic [9:0]         score_d [N_PIPES];
    logic [10:0]        speed_q [N_PIPES];
    logic [10:0]        speed_d [N_PIPES];
    logic [N_PIPES-1:0] passed_q, passed_d, grant, act_vec;
    logic               drop_q, drop_d, req_q, spawn, found;
    logic [19:0]        speed_raw;
    logic [10:0]        spawn_speed;

    // Wide enough that (score+1)*SPEED_PER_SCORE never wraps before saturation.
    assign spawn       = bus.spawnReq & ~req_q;
    assign speed_raw   = 20'(MIN_SPEED) + (20'(bus.score) + 20'd1) * 20'(SPEED_PER_SCORE);
    assign spawn_speed = (speed_raw > 20'(MAX_SPEED)) ? 11'(MAX_SPEED) : speed_raw[10:0];

    function automatic int gap_of(logic [9:0] s);
        int g;
        if (int'(s) < DOUBLE_MIN_SCORE) return 0;
        g = BASE_GAP - (int'(s) - DOUBLE_MIN_SCORE) * GAP_STEP;
        return (g < MIN_GAP) ? MIN_GAP : g;
    endfunction

    function automatic logic [9:0] top_of(logic [9:0] y, int half);
        int t;
        t = int'(y) - half;
        return (t < 0) ? 10'd0 : 10'(t);
    endfunction

    function automatic logic [9:0] bottom_of(logic [9:0] y, int half);
        int b;
        b = int'(y) + half;
        return (b > SCREEN_H - 1) ? 10'(SCREEN_H - 1) : 10'(b);
    endfunction

    always_ff @(posedge animationCLOCK or negedge resetN) begin
        if (!resetN) begin
            req_q    <= 1'b0;
            drop_q   <= 1'b0;
            passed_q <= '0;
            for (int i = 0; i < N_PIPES; i++) begin
                state_q[i] <= IDLE;
                pos_q[i]   <= '0;
                y_q[i]     <= '0;
                score_q[i] <= '0;
                speed_q[i] <= '0;
            end
        end else begin
            req_q    <= bus.spawnReq;
            drop_q   <= drop_d;
            passed_q <= passed_d;
            for (int i = 0; i < N_PIPES; i++) begin
                state_q[i] <= state_d[i];
                pos_q[i]   <= pos_d[i];
                y_q[i]     <= y_d[i];
                score_q[i] <= score_d[i];
                speed_q[i] <= speed_d[i];
            end
        end
    end

    always_comb begin
        found    = 1'b0;
        grant    = '0;
        passed_d = '0;
        for (int i = 0; i < N_PIPES; i++) begin
            state_d[i] = state_q[i];
            pos_d[i]   = pos_q[i];
            y_d[i]     = y_q[i];
            score_d[i] = score_q[i];
            speed_d[i] = speed_q[i];
        end
        // Free slots are judged on start-of-cycle state, so a retiring slot is not reusable yet.
        for (int i = 0; i < N_PIPES; i++) begin
            if (state_q[i] == IDLE && !found) begin
                found    = 1'b1;
                grant[i] = spawn;
            end
        end
        drop_d = spawn & ~found;
        for (int i = 0; i < N_PIPES; i++) begin
            case (state_q[i])
                IDLE: begin
                    if (grant[i]) begin
                        state_d[i] = ACTIVE;
                        pos_d[i]   = SPAWN_POS;
                        y_d[i]     = bus.gapY;
                        score_d[i] = bus.score;
                        speed_d[i] = spawn_speed;
                    end
                end
                ACTIVE: begin
                    if (bus.tick) begin
                        if (pos_q[i] <= XW'(speed_q[i])) begin
                            state_d[i]  = IDLE;
                            pos_d[i]    = '0;
                            passed_d[i] = 1'b1;
                        end else begin
                            pos_d[i] = pos_q[i] - XW'(speed_q[i]);
                        end
                    end
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.pipeX       = '0;
        bus.gapTop      = '0;
        bus.gapBottom   = '0;
        bus.upVisible   = '0;
        bus.downVisible = '0;
        act_vec         = '0;
        for (int i = 0; i < N_PIPES; i++) begin
            act_vec[i]               = (state_q[i] == ACTIVE);
            bus.pipeX[10*i +: 10]    = pos_q[i][XW-1:FRAC_BITS];
            bus.gapTop[10*i +: 10]   = top_of(y_q[i], gap_of(score_q[i]) / 2);
            bus.gapBottom[10*i +: 10] = bottom_of(y_q[i], gap_of(score_q[i]) / 2);
            bus.upVisible[i]   = act_vec[i] & ((int'(score_q[i]) >= DOUBLE_MIN_SCORE) | (int'(y_q[i]) <= MID));
            bus.downVisible[i] = act_vec[i] & ((int'(score_q[i]) >= DOUBLE_MIN_SCORE) | (int'(y_q[i]) > MID));
        end
    end

    assign bus.passed    = passed_q;
    assign bus.spawnDrop = drop_q;
    assign bus.allBusy   = &act_vec;
endmodule

// File: tb/tb_pipe_spawner_multi.sv
// Bench for pipe_spawner_multi: vector table, corner sequences, randomized run against a reference model.
module tb_pipe_spawner_multi;
    localparam int N = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   passes = 0;

    pipe_spawner_multi_if #(.N_PIPES(N)) bus ();
    pipe_spawner_multi #(.N_PIPES(N)) dut (.animationCLOCK(clk), .resetN(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        int score;
        int gap_y;
        int top;
        int bot;
        int up;
        int down;
    } vec_t;
    vec_t vecs [8];

    // Reference model state: one record per slot, positions in sub-pixel units.
    bit m_act [N];
    int m_pos [N];
    int m_y   [N];
    int m_sc  [N];
    bit m_passed [N];
    bit m_req;
    bit m_drop;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int px(int i);
        return int'(bus.pipeX[10*i +: 10]);
    endfunction

    function automatic int e_speed(int s);
        int v;
        v = 192 + (s + 1) * 64;
        return (v > 1024) ? 1024 : v;
    endfunction

    function automatic int e_gap(int s);
        int v;
        if (s < 10) return 0;
        v = 200 - (s - 10) * 30;
        return (v < 100) ? 100 : v;
    endfunction

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.tick     = 1'b0;
        bus.spawnReq = 1'b0;
        bus.gapY     = '0;
        bus.score    = '0;
        cyc();
        cyc();
        rst_n = 1'b1;
        m_req  = 1'b0;
        m_drop = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_act[i] = 1'b0; m_pos[i] = 0; m_y[i] = 0; m_sc[i] = 0; m_passed[i] = 1'b0;
        end
    endtask

    function automatic void model_step();
        bit edge_seen;
        int free;
        int sp;
        edge_seen = bus.spawnReq && !m_req;
        m_req     = bus.spawnReq;
        free      = -1;
        for (int i = 0; i < N; i++)
            if (!m_act[i] && free < 0) free = i;
        for (int i = 0; i < N; i++) begin
            m_passed[i] = 1'b0;
            if (m_act[i] && bus.tick) begin
                sp = e_speed(m_sc[i]);
                if (m_pos[i] <= sp) begin
                    m_act[i] = 1'b0; m_pos[i] = 0; m_passed[i] = 1'b1;
                end else begin
                    m_pos[i] -= sp;
                end
            end
        end
        m_drop = 1'b0;
        if (edge_seen) begin
            if (free >= 0) begin
                m_act[free] = 1'b1;
                m_pos[free] = 650 * 128;
                m_y[free]   = int'(bus.gapY);
                m_sc[free]  = int'(bus.score);
            end else begin
                m_drop = 1'b1;
            end
        end
    endfunction

    task automatic compare_model(int cyc_no);
        int half, e_top, e_bot, busy;
        bit dbl;
        busy = 1;
        for (int i = 0; i < N; i++) begin
            half  = e_gap(m_sc[i]) / 2;
            e_top = (m_y[i] - half < 0) ? 0 : m_y[i] - half;
            e_bot = (m_y[i] + half > 479) ? 479 : m_y[i] + half;
            dbl   = (m_sc[i] >= 10);
            chk($sformatf("rnd%0d pipeX[%0d]", cyc_no, i), px(i), m_pos[i] / 128);
            if (m_act[i]) begin
                chk($sformatf("rnd%0d gapTop[%0d]", cyc_no, i), int'(bus.gapTop[10*i +: 10]), e_top);
                chk($sformatf("rnd%0d gapBottom[%0d]", cyc_no, i), int'(bus.gapBottom[10*i +: 10]), e_bot);
            end
            chk($sformatf("rnd%0d up[%0d]", cyc_no, i), int'(bus.upVisible[i]),
                int'(m_act[i] && (dbl || m_y[i] <= 240)));
            chk($sformatf("rnd%0d down[%0d]", cyc_no, i), int'(bus.downVisible[i]),
                int'(m_act[i] && (dbl || m_y[i] > 240)));
            chk($sformatf("rnd%0d passed[%0d]", cyc_no, i), int'(bus.passed[i]), int'(m_passed[i]));
            if (!m_act[i]) busy = 0;
        end
        chk($sformatf("rnd%0d spawnDrop", cyc_no), int'(bus.spawnDrop), int'(m_drop));
        chk($sformatf("rnd%0d allBusy", cyc_no), int'(bus.allBusy), busy);
    endtask

    initial begin
        int ticks;
        bit got;
        vecs[0] = '{0,  240, 240, 240, 1, 0};
        vecs[1] = '{12, 240, 170, 310, 1, 1};
        vecs[2] = '{20, 40,  0,   90,  1, 1};
        vecs[3] = '{5,  300, 300, 300, 0, 1};
        vecs[4] = '{10, 240, 140, 340, 1, 1};
        vecs[5] = '{13, 10,  0,   65,  1, 1};
        vecs[6] = '{30, 470, 420, 479, 1, 1};
        vecs[7] = '{9,  241, 241, 241, 0, 1};

        bus.tick = 1'b0; bus.spawnReq = 1'b0; bus.gapY = '0; bus.score = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("reset pipeX", int'(bus.pipeX), 0);
        chk("reset gapTop", int'(bus.gapTop), 0);
        chk("reset gapBottom", int'(bus.gapBottom), 0);
        chk("reset up", int'(bus.upVisible), 0);
        chk("reset down", int'(bus.downVisible), 0);
        chk("reset passed", int'(bus.passed), 0);
        chk("reset spawnDrop", int'(bus.spawnDrop), 0);
        chk("reset allBusy", int'(bus.allBusy), 0);

        for (int v = 0; v < 8; v++) begin
            do_reset();
            bus.score    = 10'(vecs[v].score);
            bus.gapY     = 10'(vecs[v].gap_y);
            bus.spawnReq = 1'b1;
            cyc();
            bus.spawnReq = 1'b0;
            chk($sformatf("vec%0d pipeX", v), px(0), 650);
            chk($sformatf("vec%0d gapTop", v), int'(bus.gapTop[9:0]), vecs[v].top);
            chk($sformatf("vec%0d gapBottom", v), int'(bus.gapBottom[9:0]), vecs[v].bot);
            chk($sformatf("vec%0d up", v), int'(bus.upVisible[0]), vecs[v].up);
            chk($sformatf("vec%0d down", v), int'(bus.downVisible[0]), vecs[v].down);
        end

        // Score 0: 2 px per tick, retires on the 325th tick.
        do_reset();
        bus.tick = 1'b1; bus.spawnReq = 1'b1;
        cyc();
        bus.spawnReq = 1'b0;
        chk("slow pipeX spawn", px(0), 650);
        cyc();
        chk("slow pipeX t1", px(0), 648);
        cyc();
        chk("slow pipeX t2", px(0), 646);
        ticks = 2; got = 1'b0;
        while (ticks < 400 && !got) begin
            cyc();
            ticks++;
            if (bus.passed[0]) got = 1'b1;
        end
        chk("retire tick", ticks, 325);
        chk("retire up", int'(bus.upVisible[0]), 0);
        chk("retire pipeX", px(0), 0);
        cyc();
        chk("passed one cycle", int'(bus.passed[0]), 0);

        // Held request spawns once; three more edges fill the slots then drop.
        do_reset();
        bus.spawnReq = 1'b1;
        repeat (3) cyc();
        chk("held spawn up", int'(bus.upVisible), 1);
        chk("held allBusy", int'(bus.allBusy), 0);
        for (int e = 1; e <= 3; e++) begin
            bus.spawnReq = 1'b0;
            cyc();
            bus.spawnReq = 1'b1;
            cyc();
            chk($sformatf("edge%0d up", e), int'(bus.upVisible), (e == 1) ? 3 : 7);
            chk($sformatf("edge%0d allBusy", e), int'(bus.allBusy), (e == 1) ? 0 : 1);
            chk($sformatf("edge%0d spawnDrop", e), int'(bus.spawnDrop), (e == 3) ? 1 : 0);
        end
        bus.spawnReq = 1'b0;
        cyc();
        chk("spawnDrop pulse end", int'(bus.spawnDrop), 0);

        // Saturated speed, then asynchronous reset mid-flight.
        do_reset();
        bus.score = 10'd30; bus.gapY = 10'd200; bus.tick = 1'b1; bus.spawnReq = 1'b1;
        cyc();
        bus.spawnReq = 1'b0;
        chk("fast pipeX spawn", px(0), 650);
        cyc();
        chk("fast pipeX t1", px(0), 642);
        #2 rst_n = 1'b0;
        #1;
        chk("async pipeX", int'(bus.pipeX), 0);
        chk("async up", int'(bus.upVisible), 0);
        chk("async down", int'(bus.downVisible), 0);
        chk("async gapTop", int'(bus.gapTop), 0);
        chk("async gapBottom", int'(bus.gapBottom), 0);
        chk("async passed", int'(bus.passed), 0);
        @(negedge clk);

        // Randomized run against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bus.tick  = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 3) == 0) bus.spawnReq = ~bus.spawnReq;
            bus.score = 10'($urandom_range(0, 40));
            bus.gapY  = 10'($urandom_range(0, 520));
            @(posedge clk);
            model_step();
            @(negedge clk);
            compare_model(c);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
